// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output unloader: frame geometry, the
// unloader state encoding and the digit-reverse address mapping.
package fft_pkg;

  localparam int N_FFT      = 2048;
  localparam int N_BANK     = 4;
  localparam int BANK_AW    = 9;
  localparam int IDX_W      = 11;
  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } unload_state_e;

  // Natural frequency index k -> storage location of that bin in the
  // result banks. Radix-4 digits are swapped end for end; the lone radix-2
  // digit (k[10]) lands in the LSB.
  function automatic logic [IDX_W-1:0] digit_rev(input logic [IDX_W-1:0] k);
    return {k[1:0], k[3:2], k[5:4], k[7:6], k[9:8], k[10]};
  endfunction

endpackage

// File: rtl/fft_sync_fifo.sv
// Small synchronous FIFO with show-ahead head output, full/empty flags and
// an occupancy count. Depth need not be a power of two.
module fft_sync_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_ok = rd_en & ~empty;
  // A write into a full FIFO is accepted only when the head leaves this cycle.
  assign wr_ok = wr_en & (~full | rd_ok);
  assign head  = mem[rd_ptr];

  // Storage, pointers and count; storage is cleared so the head reads zero
  // after reset.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/fft_unload.sv
// Reads a finished 2048-point spectrum out of the four result banks in
// digit-reversed order and streams it in natural frequency order over a
// valid/ready interface.
//
// Stream handshake: a beat transfers in every cycle where oVALID and iREADY
// are both high. oVALID never drops and the beat (data, index, SOP, EOP)
// never changes until that beat has transferred.
module fft_unload
  import fft_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int REVERSE    = 1
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic          iSTART,
  output logic [1:0]    oBANK,
  output logic [8:0]    oADDR,
  input  logic [DW-1:0] iRD_RE,
  input  logic [DW-1:0] iRD_IM,
  output logic          oVALID,
  input  logic          iREADY,
  output logic [DW-1:0] oDATA_RE,
  output logic [DW-1:0] oDATA_IM,
  output logic [10:0]   oINDEX,
  output logic          oSOP,
  output logic          oEOP,
  output logic          oBUSY,
  output logic          oDONE
);

  localparam int FW = 2 * DW + IDX_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  unload_state_e    state;
  unload_state_e    state_nxt;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] loc;
  logic             issue;
  logic             done_nxt;
  logic             done_q;
  logic [1:0]       bank_q;
  logic [8:0]       addr_q;

  // Stage registered together with the address, then RD_LAT stages so the
  // tap lines up with the read data returning from the bank mux.
  logic             iss_v;
  logic [IDX_W-1:0] iss_k;
  logic [RD_LAT-1:0] pipe_v;
  logic [IDX_W-1:0] pipe_k [RD_LAT];
  logic             tap;

  logic [CW-1:0]    inflight;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_valid;
  logic [FW-1:0]    head;
  logic [IDX_W-1:0] head_k;
  logic             head_eop;
  logic             pop;
  logic [OW-1:0]    occ;
  logic             credit_ok;

  assign loc = (REVERSE != 0) ? digit_rev(k) : k;
  assign tap = pipe_v[RD_LAT-1];

  assign fifo_valid = ~fifo_empty;
  assign pop        = fifo_valid & iREADY;
  assign head_k     = head[IDX_W-1:0];
  assign head_eop   = fifo_valid & (head_k == IDX_W'(N_FFT - 1));

  // Slots already promised (in flight or sitting in the FIFO), counting a
  // pop in this cycle as already free: a read issued now lands no earlier
  // than the pop, so the FIFO can never be over-committed, and issue
  // restarts with the address change right after a freeing pop.
  assign occ       = OW'(inflight) + OW'(fifo_count) - OW'(pop);
  assign credit_ok = (occ < OW'(FIFO_DEPTH)) && !(fifo_full && !pop);

  // Next-state and issue decision.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (iSTART) begin
          issue     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (k == IDX_W'(N_FFT - 1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_eop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, issue counter and registered bank/address. k wraps from 2047 to
  // 0 on the last issue, so it is already cleared for the next frame.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state  <= IDLE;
      k      <= '0;
      bank_q <= '0;
      addr_q <= '0;
      iss_v  <= 1'b0;
      iss_k  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      iss_v  <= issue;
      if (issue) begin
        k      <= k + IDX_W'(1);
        bank_q <= loc[IDX_W-1:BANK_AW];
        addr_q <= loc[BANK_AW-1:0];
        iss_k  <= k;
      end
    end
  end

  // Read-latency pipe carrying the index of each outstanding read.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_k[i] <= '0;
    end else begin
      pipe_v[0] <= iss_v;
      pipe_k[0] <= iss_k;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_k[i] <= pipe_k[i-1];
      end
    end
  end

  // Reads issued whose data has not yet been written into the FIFO.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) inflight <= '0;
    else         inflight <= inflight + CW'(issue) - CW'(tap);
  end

  fft_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iCLK    (iCLK),
    .iRESET  (iRESET),
    .wr_en   (tap),
    .wr_data ({iRD_RE, iRD_IM, pipe_k[RD_LAT-1]}),
    .rd_en   (pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign oBANK    = bank_q;
  assign oADDR    = addr_q;
  assign oVALID   = fifo_valid;
  assign oDATA_RE = head[FW-1 -: DW];
  assign oDATA_IM = head[IDX_W +: DW];
  assign oINDEX   = head_k;
  assign oSOP     = fifo_valid & (head_k == '0);
  assign oEOP     = head_eop;
  assign oBUSY    = (state != IDLE);
  assign oDONE    = done_q;

endmodule

// File: tb/tb_fft_unload.sv
// Bench for fft_unload: random RAM contents and random backpressure checked
// against a frame-level model held in an expected-beat queue.
module tb_fft_unload;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int EW = 2 * DW + 11 + 2;

  logic          iCLK;
  logic          iRESET;
  logic          iSTART;
  logic          iREADY;
  logic [1:0]    oBANK;
  logic [8:0]    oADDR;
  logic [DW-1:0] iRD_RE, iRD_IM;
  logic          oVALID, oSOP, oEOP, oBUSY, oDONE;
  logic [DW-1:0] oDATA_RE, oDATA_IM;
  logic [10:0]   oINDEX;

  // Second instance in linear (bring-up) order with its own RAM.
  logic          lin_ready;
  logic [1:0]    lin_bank;
  logic [8:0]    lin_addr;
  logic [DW-1:0] lin_rd_re, lin_rd_im, lin_re, lin_im;
  logic          lin_valid, lin_sop, lin_eop, lin_busy, lin_done;
  logic [10:0]   lin_index;

  fft_unload dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .oBANK(oBANK), .oADDR(oADDR), .iRD_RE(iRD_RE), .iRD_IM(iRD_IM),
    .oVALID(oVALID), .iREADY(iREADY), .oDATA_RE(oDATA_RE), .oDATA_IM(oDATA_IM),
    .oINDEX(oINDEX), .oSOP(oSOP), .oEOP(oEOP), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  fft_unload #(.REVERSE(0)) u_lin (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .oBANK(lin_bank), .oADDR(lin_addr), .iRD_RE(lin_rd_re), .iRD_IM(lin_rd_im),
    .oVALID(lin_valid), .iREADY(lin_ready), .oDATA_RE(lin_re), .oDATA_IM(lin_im),
    .oINDEX(lin_index), .oSOP(lin_sop), .oEOP(lin_eop), .oBUSY(lin_busy), .oDONE(lin_done)
  );

  // ---------------- clock / reset / cycle count ----------------
  int cyc = 0;
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  initial begin
    repeat (60000) @(posedge iCLK);
    $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- RAM models (2-cycle read latency) ----------------
  logic [15:0] salt = 16'h0;
  logic [10:0] h0, h1, lh0, lh1;

  function automatic logic [15:0] ram_re(input logic [10:0] loc, input logic [15:0] s);
    return 16'(loc) + s;
  endfunction
  function automatic logic [15:0] ram_im(input logic [10:0] loc, input logic [15:0] s);
    return {loc[4:0], loc} ^ s ^ 16'h5A3C;
  endfunction

  always @(posedge iCLK) begin
    h0  <= {oBANK, oADDR};
    h1  <= h0;
    lh0 <= {lin_bank, lin_addr};
    lh1 <= lh0;
  end
  assign iRD_RE    = ram_re(h1, salt);
  assign iRD_IM    = ram_im(h1, salt);
  assign lin_rd_re = 16'(lh1);
  assign lin_rd_im = ~16'(lh1);

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  start_cyc = 0;
  int  beats = 0;
  int  done_cnt = 0;
  int  done_due = 0;
  bit  done_pend = 0;
  bit  full_rate = 0;
  bit  chk_issue = 0;
  int  rdy_mode = 0;
  logic [10:0] lin_next = '0;
  int          iss_k   [5] = '{0, 1, 2, 4, 1024};
  logic [10:0] iss_loc [5] = '{11'h000, 11'h200, 11'h400, 11'h080, 11'h001};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, {oBANK, oADDR, oVALID, oDATA_RE, oDATA_IM, oINDEX, oSOP, oEOP, oBUSY, oDONE}, 64'd0);
  endtask

  // ---------------- drivers ----------------
  initial begin
    iREADY = 1'b1;
    forever begin
      @(posedge iCLK); #1;
      case (rdy_mode)
        0:       iREADY = 1'b1;
        1:       iREADY = 1'($urandom_range(0, 1));
        default: iREADY = 1'b0;
      endcase
    end
  end

  // Push the model of a whole frame, then pulse iSTART (called #1 after a posedge).
  task automatic start_frame(input bit full, input bit issue_chk);
    logic [10:0] kk, loc;
    for (int k = 0; k < N_FFT; k++) begin
      kk  = 11'(k);
      loc = digit_rev(kk);
      exp_q.push_back({ram_re(loc, salt), ram_im(loc, salt), kk, k == 0, k == N_FFT - 1});
    end
    full_rate = full;
    chk_issue = issue_chk;
    beats     = 0;
    done_cnt  = 0;
    start_cyc = cyc;
    iSTART    = 1'b1;
    @(posedge iCLK); #1;
    iSTART    = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while ((cyc - start_cyc) < n) begin @(posedge iCLK); #1; end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!oDONE && n < budget) begin @(negedge iCLK); n++; end
    chk("frame_done_seen", oDONE, 1'b1);
    @(posedge iCLK); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] cur, held, e;
    bit stalled;
    int rel;
    stalled = 0;
    held    = '0;
    forever begin
      @(negedge iCLK);
      if (!iRESET) begin stalled = 0; continue; end
      rel = cyc - start_cyc;
      if (chk_issue)
        for (int i = 0; i < 5; i++)
          if (rel == iss_k[i] + 1) chk("issue_addr", {oBANK, oADDR}, iss_loc[i]);
      if (oBUSY) chk("occupancy_le_depth", (int'(dut.inflight) + int'(dut.fifo_count)) <= 4, 1'b1);
      cur = {oDATA_RE, oDATA_IM, oINDEX, oSOP, oEOP};
      if (stalled) chk("stall_hold", {oVALID, cur}, {1'b1, held});
      if (oVALID && iREADY) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat @cyc %0d: got index %0d, required no beat", cyc, oINDEX);
        end else begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
        if (beats == 0 && full_rate) chk("first_beat_cycle", rel, 4);
        if (oEOP) begin
          if (full_rate) chk("last_beat_cycle", rel, 2051);
          done_due  = cyc + 1;
          done_pend = 1;
        end
        beats++;
        stalled = 0;
      end else if (oVALID) begin
        stalled = 1;
        held    = cur;
      end else stalled = 0;
      if (oDONE || (done_pend && cyc == done_due)) chk("done_pulse", oDONE, done_pend && cyc == done_due);
      if (done_pend && cyc >= done_due) done_pend = 0;
      if (oDONE) done_cnt++;
    end
  end

  // Linear-order instance: every sample equals its own index, in order.
  initial begin
    lin_ready = 1'b1;
    forever begin
      @(negedge iCLK);
      if (iRESET && lin_valid) begin
        chk("lin_index", lin_index, lin_next);
        chk("lin_data", {lin_re, lin_im}, {16'(lin_index), ~16'(lin_index)});
        chk("lin_marks", {lin_sop, lin_eop}, {lin_next == 11'd0, lin_next == 11'd2047});
        lin_next = lin_next + 11'd1;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int guard;
    iRESET = 1'b0;
    iSTART = 1'b0;
    repeat (3) @(posedge iCLK); #1;
    check_zero("reset_state");
    iRESET = 1'b1;
    repeat (2) @(posedge iCLK); #1;

    // Frame A: full rate, issue-order spot checks.
    salt = 16'($urandom);
    rdy_mode = 0;
    start_frame(1, 1);
    wait_done(3000);
    repeat (20) @(posedge iCLK); #1;
    chk("frameA_done_count", done_cnt, 1);
    chk("frameA_bank_addr_held", {oBANK, oADDR}, 11'h7FF);

    // Frame B: random backpressure, a 100-cycle stall, stray iSTART at 500.
    salt = 16'($urandom);
    rdy_mode = 1;
    start_frame(0, 0);
    wait_rel(500);
    iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    wait_rel(1200);
    rdy_mode = 2;
    wait_rel(1300);
    rdy_mode = 1;
    wait_done(12000);
    rdy_mode = 0;
    repeat (20) @(posedge iCLK); #1;
    chk("frameB_done_count", done_cnt, 1);
    chk("frameB_queue_empty", exp_q.size(), 0);

    // Frame C: reset after 1000 beats.
    salt = 16'($urandom);
    start_frame(1, 0);
    guard = 0;
    while (beats < 1000 && guard < 5000) begin @(posedge iCLK); #1; guard++; end
    chk("frameC_reached_beat_1000", beats >= 1000, 1'b1);
    iRESET = 1'b0;
    exp_q.delete();
    done_pend = 0;
    lin_next  = '0;
    @(negedge iCLK);
    check_zero("reset_mid_frame");
    repeat (3) @(posedge iCLK); #1;
    iRESET = 1'b1;
    repeat (5) @(posedge iCLK); #1;
    chk("no_partial_done", done_cnt, 0);

    // Frames D and E: clean frame after reset, then back-to-back repeat.
    salt = 16'($urandom);
    start_frame(1, 1);
    wait_done(3000);
    start_frame(1, 1);
    wait_done(3000);
    repeat (20) @(posedge iCLK); #1;
    chk("frameE_done_count", done_cnt, 1);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_idle", {oBUSY, oVALID}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
